comparador_serial_der_izq: RTL and testbench

- Bit-serial magnitude comparator that drives the right-to-left cell chain.
- Loads two WIDTH-bit operands, then presents one bit pair (A, B) per clock, LSB first.
- Bit 0 goes to the initial-cell function; each later bit goes to the propagation-cell function.
- Accumulates the running "A greater" term P and reports gt/eq/lt with a start/done handshake.

---
 rtl/cmp_pkg.sv | 15 +
 rtl/celda_propagacion_cmp.sv | 44 ++++
 rtl/comparador_serial_der_izq.sv | 158 +++++++++++++++
 tb/tb_comparador_serial_der_izq.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared constants and types for the serial comparator
//
// Purpose: FSM state encoding and default operand width used by
//          comparador_serial_der_izq and its bench.
package cmp_pkg;

    localparam int CMP_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } cmp_state_t;

endpackage

// File: rtl/celda_propagacion_cmp.sv
// rtl/celda_propagacion_cmp.sv - combinational 1-bit update of the right-to-left comparator chain
//
// Purpose: computes the next running "A greater" term (P) and the running
//          equality term (E) from one bit pair.
// Ports:
//   a, b        in   current bit pair
//   p_prev      in   running P from less significant bits
//   e_prev      in   running E from less significant bits
//   first       in   1 for bit 0 (initial cell), 0 for propagation cells
//   msb_signed  in   1 when the pair is a two's-complement sign bit
//   p_next      out  updated P
//   e_next      out  updated E
module celda_propagacion_cmp (
    input  logic a,
    input  logic b,
    input  logic p_prev,
    input  logic e_prev,
    input  logic first,
    input  logic msb_signed,
    output logic p_next,
    output logic e_next
);

    logic differ;

    assign differ = a ^ b;

    always_comb begin
        p_next = p_prev;
        e_next = e_prev;
        if (first) begin
            p_next = a & ~b;
            e_next = ~differ;
        end else begin
            // A more significant differing bit overrides whatever the lower
            // bits decided; a sign bit carries the opposite weight.
            if (differ) begin
                p_next = msb_signed ? b : a;
            end
            e_next = e_prev & ~differ;
        end
    end

endmodule

// File: rtl/comparador_serial_der_izq.sv
// rtl/comparador_serial_der_izq.sv - bit-serial LSB-first magnitude comparator
//
// Purpose: loads two WIDTH-bit operands on start, feeds one bit pair per
//          clock (LSB first) through a single reused comparator cell and
//          reports gt/eq/lt with a one-cycle done pulse.
// Optional: COMPARADOR_SIGNED_CMP_EN selects two's-complement comparison.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request a comparison (sampled only in IDLE)
//   op_a   in   operand A, captured on an accepted start
//   op_b   in   operand B, captured on an accepted start
//   busy   out  high in SHIFT or DONE
//   done   out  one-cycle pulse when gt/eq/lt become valid
//   bit_a  out  A bit currently presented to the cell
//   bit_b  out  B bit currently presented to the cell
//   gt     out  A > B
//   eq     out  A == B
//   lt     out  A < B
module comparador_serial_der_izq
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH_DEFAULT,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             bit_a,
    output logic             bit_b,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    cmp_state_t       state;
    cmp_state_t       state_nxt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CNT_W-1:0] cnt;
    logic             p_reg;
    logic             e_reg;
    logic             p_nxt;
    logic             e_nxt;
    logic             load;
    logic             shift_en;
    logic             finish;
    logic             last_bit;
    logic             first_bit;
    logic             msb_signed;

    assign last_bit  = (cnt == CNT_W'(WIDTH - 1));
    assign first_bit = (cnt == '0);
    assign bit_a     = sh_a[0];
    assign bit_b     = sh_b[0];

`ifdef COMPARADOR_SIGNED_CMP_EN
    assign msb_signed = last_bit;
`else
    assign msb_signed = 1'b0;
`endif

    celda_propagacion_cmp u_celda (
        .a          (sh_a[0]),
        .b          (sh_b[0]),
        .p_prev     (p_reg),
        .e_prev     (e_reg),
        .first      (first_bit),
        .msb_signed (msb_signed),
        .p_next     (p_nxt),
        .e_next     (e_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift_en  = 1'b0;
        finish    = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                if (last_bit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                finish    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a  <= '0;
            sh_b  <= '0;
            cnt   <= '0;
            p_reg <= 1'b0;
            e_reg <= 1'b1;
        end else if (load) begin
            sh_a <= op_a;
            sh_b <= op_b;
            cnt  <= '0;
        end else if (shift_en) begin
            sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
            sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
            p_reg <= p_nxt;
            e_reg <= e_nxt;
            // Hold on the last index so a power-of-two WIDTH never wraps.
            if (!last_bit) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Results are registered on leaving DONE, so done and the flags appear
    // together in the following cycle and then hold until the next result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
            gt   <= 1'b0;
            eq   <= 1'b0;
            lt   <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
                gt <= p_reg & ~e_reg;
                eq <= e_reg;
                lt <= ~p_reg & ~e_reg;
            end
        end
    end

endmodule

// File: tb/tb_comparador_serial_der_izq.sv
// tb/tb_comparador_serial_der_izq.sv - self-checking bench for comparador_serial_der_izq
module tb_comparador_serial_der_izq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         busy, done, bit_a, bit_b, gt, eq, lt;

    int errors = 0;
    int checks = 0;
    int done_count = 0;

    comparador_serial_der_izq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .busy  (busy),
        .done  (done),
        .bit_a (bit_a),
        .bit_b (bit_b),
        .gt    (gt),
        .eq    (eq),
        .lt    (lt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_count++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer comparison of the operands; returns {gt,eq,lt}.
    function automatic logic [2:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b);
        int ia, ib;
`ifdef COMPARADOR_SIGNED_CMP_EN
        ia = int'($signed(a));
        ib = int'($signed(b));
`else
        ia = int'(a);
        ib = int'(b);
`endif
        return {ia > ib, ia == ib, ia < ib};
    endfunction

    task automatic do_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input bit start_while_busy);
        int j;
        int dc0;
        logic [2:0] exp;
        exp = ref_cmp(a, b);
        @(negedge clk);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        @(posedge clk);
        #1;
        if (start_while_busy) begin
            op_a = 8'hFF;
            op_b = 8'h00;
        end else begin
            start = 1'b0;
            op_a  = W'($urandom);
            op_b  = W'($urandom);
        end
        dc0 = done_count;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("busy_shift", busy, 1);
            chk("bit_a_stream", bit_a, a[i]);
            chk("bit_b_stream", bit_b, b[i]);
        end
        start = 1'b0;
        j = W;
        do begin
            @(negedge clk);
            j++;
        end while (done !== 1'b1 && j < W + 8);
        chk("done_latency", j, W + 2);
        chk("gt", gt, exp[2]);
        chk("eq", eq, exp[1]);
        chk("lt", lt, exp[0]);
        chk("busy_at_done", busy, 0);
        @(negedge clk);
        chk("done_pulse_width", done, 0);
        chk("done_pulse_count", done_count - dc0, 1);
        chk("flags_hold_idle", {gt, eq, lt}, exp);
    endtask

    initial begin
        logic [W-1:0] ra, rb;

        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_flags", {gt, eq, lt}, 3'b000);
        chk("reset_bits", {bit_a, bit_b}, 2'b00);
        rst_n = 1'b1;

        // Abort mid-SHIFT with an asynchronous reset.
        @(negedge clk);
        start = 1'b1;
        op_a  = 8'hF0;
        op_b  = 8'h0F;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_abort_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_flags", {gt, eq, lt}, 3'b000);
        chk("abort_bits", {bit_a, bit_b}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (14) @(negedge clk);
        chk("abort_no_done", done_count, 0);
        chk("abort_idle_busy", busy, 0);

        do_cmp(8'h80, 8'h7F, 1'b0);
        do_cmp(8'hA5, 8'hA5, 1'b0);
        do_cmp(8'h00, 8'h00, 1'b0);
        do_cmp(8'h10, 8'h11, 1'b0);
        do_cmp(8'h11, 8'h10, 1'b0);
        do_cmp(8'h10, 8'h11, 1'b1);
        do_cmp(8'hFF, 8'h00, 1'b0);
        do_cmp(8'h7F, 8'h80, 1'b0);

        for (int n = 0; n < 24; n++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
            do_cmp(ra, rb, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
